lateral_inhibition_wta: RTL and testbench

LATERAL_INHIBITION_WTA -- requirements
Module: lateral_inhibition_wta

---
 rtl/lateral_inhibition_wta.sv | 132 +++++++++++++
 tb/tb_lateral_inhibition_wta.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lateral_inhibition_wta.sv
// Winner-take-all lateral inhibition for one excitatory column: the first spike of a
// gamma period passes, all later spikes are suppressed. Define WTA_RR_TIE_EN for round-robin tie-break.

`ifndef NEURONS_PER_COLUMN
`define NEURONS_PER_COLUMN 4
`endif
`ifndef TIME_PERIOD
`define TIME_PERIOD 8
`endif

module lateral_inhibition_wta #(
   parameter int NEURONS = `NEURONS_PER_COLUMN,
   parameter int PERIOD  = `TIME_PERIOD,
   parameter int TW      = $clog2(PERIOD),
   parameter int IW      = $clog2(NEURONS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_counter,
   input  logic [TW-1:0]      cycle,
   input  logic [NEURONS-1:0] in_spikes,
   output logic [NEURONS-1:0] out_spikes,
   output logic               winner_valid,
   output logic [IW-1:0]      winner_idx,
   output logic [TW-1:0]      winner_time,
   output logic               period_done
);

   typedef enum logic {ARMED = 1'b0, LOCKED = 1'b1} state_t;

   state_t          state_q, state_d;
   logic            winner_valid_q, winner_valid_d;
   logic [IW-1:0]   winner_idx_q, winner_idx_d;
   logic [TW-1:0]   winner_time_q, winner_time_d;
   logic            period_done_q, period_done_d;

   logic            step_valid;
   logic            period_start;
   logic            period_close;
   logic            win;
   logic [IW-1:0]   sel_idx;

   assign step_valid   = en_counter && !rst;
   assign period_start = (cycle == '0);
   assign period_close = (cycle == TW'(PERIOD - 1));

`ifdef WTA_RR_TIE_EN
   logic [IW-1:0] ptr_q, ptr_d;

   // Scan downward so the first set bit at or after the pointer is the last one assigned.
   always_comb begin
      int j;
      sel_idx = '0;
      j       = 0;
      for (int k = NEURONS - 1; k >= 0; k--) begin
         j = int'(ptr_q) + k;
         if (j >= NEURONS) j = j - NEURONS;
         if (in_spikes[j]) sel_idx = IW'(j);
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (win) ptr_d = (int'(sel_idx) == NEURONS - 1) ? '0 : sel_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   always_comb begin
      sel_idx = '0;
      for (int i = NEURONS - 1; i >= 0; i--) begin
         if (in_spikes[i]) sel_idx = IW'(i);
      end
   end
`endif

   // A cycle-0 step re-arms even if the previous period close was missed.
   assign win = step_valid && |in_spikes && ((state_q == ARMED) || period_start);

   generate
      for (genvar gi = 0; gi < NEURONS; gi++) begin : g_out
         assign out_spikes[gi] = win && (sel_idx == IW'(gi));
      end
   endgenerate

   always_comb begin
      state_d        = state_q;
      winner_valid_d = winner_valid_q;
      winner_idx_d   = winner_idx_q;
      winner_time_d  = winner_time_q;
      period_done_d  = 1'b0;
      if (step_valid) begin
         if (period_close)      state_d = ARMED;
         else if (win)          state_d = LOCKED;
         else if (period_start) state_d = ARMED;

         if (win) begin
            winner_valid_d = 1'b1;
            winner_idx_d   = sel_idx;
            winner_time_d  = cycle;
         end else if (period_start) begin
            winner_valid_d = 1'b0;
         end
         period_done_d = period_close;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ARMED;
         winner_valid_q <= 1'b0;
         winner_idx_q   <= '0;
         winner_time_q  <= '0;
         period_done_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         winner_valid_q <= winner_valid_d;
         winner_idx_q   <= winner_idx_d;
         winner_time_q  <= winner_time_d;
         period_done_q  <= period_done_d;
      end
   end

   assign winner_valid = winner_valid_q;
   assign winner_idx   = winner_idx_q;
   assign winner_time  = winner_time_q;
   assign period_done  = period_done_q;

endmodule

// File: tb/tb_lateral_inhibition_wta.sv
// Directed bench for lateral_inhibition_wta with NEURONS=4, PERIOD=8.
module tb_lateral_inhibition_wta;

   logic       clk;
   logic       rst;
   logic       en_counter;
   logic [2:0] cycle;
   logic [3:0] in_spikes;
   logic [3:0] out_spikes;
   logic       winner_valid;
   logic [1:0] winner_idx;
   logic [2:0] winner_time;
   logic       period_done;

   int checks = 0;
   int passes = 0;

   lateral_inhibition_wta #(.NEURONS(4), .PERIOD(8)) dut (
      .clk(clk),
      .rst(rst),
      .en_counter(en_counter),
      .cycle(cycle),
      .in_spikes(in_spikes),
      .out_spikes(out_spikes),
      .winner_valid(winner_valid),
      .winner_idx(winner_idx),
      .winner_time(winner_time),
      .period_done(period_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic e, input logic [2:0] c, input logic [3:0] s);
      @(negedge clk);
      en_counter = e;
      cycle      = c;
      in_spikes  = s;
      #1;
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b1, 3'd0, 4'b1111);
      checks++;
      if (out_spikes !== 4'b0000) $display("FAIL rst_out: got %b want 0000", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if ({winner_valid, winner_idx, winner_time, period_done} !== 7'b0)
         $display("FAIL rst_regs: got v=%b i=%0d t=%0d pd=%b want all 0",
                  winner_valid, winner_idx, winner_time, period_done);
      else passes++;
      $display("reset: out=%b v=%b i=%0d t=%0d pd=%b", out_spikes, winner_valid, winner_idx, winner_time, period_done);
      rst = 1'b0;
   endtask

   task automatic test_single_spike();
      set_in(1'b1, 3'd3, 4'b0100);
      checks++;
      if (out_spikes !== 4'b0100) $display("FAIL single_out: got %b want 0100", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if (winner_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", winner_valid);
      else passes++;
      checks++;
      if (winner_idx !== 2'd2) $display("FAIL single_idx: got %0d want 2", winner_idx);
      else passes++;
      checks++;
      if (winner_time !== 3'd3) $display("FAIL single_time: got %0d want 3", winner_time);
      else passes++;
      $display("single: v=%b i=%0d t=%0d", winner_valid, winner_idx, winner_time);
   endtask

   task automatic test_suppression();
      set_in(1'b1, 3'd4, 4'b1111);
      checks++;
      if (out_spikes !== 4'b0000) $display("FAIL supp_out: got %b want 0000", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if ({winner_valid, winner_idx, winner_time} !== {1'b1, 2'd2, 3'd3})
         $display("FAIL supp_regs: got v=%b i=%0d t=%0d want v=1 i=2 t=3", winner_valid, winner_idx, winner_time);
      else passes++;
      $display("suppress: out=%b v=%b i=%0d t=%0d", out_spikes, winner_valid, winner_idx, winner_time);
   endtask

   task automatic test_gating_locked();
      set_in(1'b0, 3'd5, 4'b1111);
      checks++;
      if (out_spikes !== 4'b0000) $display("FAIL gate_out: got %b want 0000", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if ({winner_valid, winner_idx, winner_time, period_done} !== {1'b1, 2'd2, 3'd3, 1'b0})
         $display("FAIL gate_regs: got v=%b i=%0d t=%0d pd=%b want 1 2 3 0",
                  winner_valid, winner_idx, winner_time, period_done);
      else passes++;
      set_in(1'b1, 3'd5, 4'b0001);
      checks++;
      if (out_spikes !== 4'b0000) $display("FAIL gate_still_locked: got %b want 0000", out_spikes);
      else passes++;
      clk_edge();
      $display("gating: out=%b v=%b i=%0d", out_spikes, winner_valid, winner_idx);
   endtask

   task automatic test_period_close();
      set_in(1'b1, 3'd6, 4'b0000);
      clk_edge();
      set_in(1'b1, 3'd7, 4'b0010);
      checks++;
      if (out_spikes !== 4'b0000) $display("FAIL close_locked_out: got %b want 0000", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if (period_done !== 1'b1) $display("FAIL close_pd: got %b want 1", period_done);
      else passes++;
      checks++;
      if ({winner_valid, winner_idx} !== {1'b1, 2'd2})
         $display("FAIL close_hold: got v=%b i=%0d want v=1 i=2", winner_valid, winner_idx);
      else passes++;
      set_in(1'b1, 3'd0, 4'b0000);
      clk_edge();
      checks++;
      if (winner_valid !== 1'b0) $display("FAIL clear_valid: got %b want 0", winner_valid);
      else passes++;
      checks++;
      if (period_done !== 1'b0) $display("FAIL clear_pd: got %b want 0", period_done);
      else passes++;
      $display("close: v=%b pd=%b", winner_valid, period_done);
   endtask

   task automatic test_closing_winner();
      for (int c = 1; c < 7; c++) begin
         set_in(1'b1, 3'(c), 4'b0000);
         clk_edge();
      end
      checks++;
      if (winner_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", winner_valid);
      else passes++;
      set_in(1'b1, 3'd7, 4'b1000);
      checks++;
      if (out_spikes !== 4'b1000) $display("FAIL closew_out: got %b want 1000", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if ({period_done, winner_valid, winner_idx, winner_time} !== {1'b1, 1'b1, 2'd3, 3'd7})
         $display("FAIL closew_regs: got pd=%b v=%b i=%0d t=%0d want 1 1 3 7",
                  period_done, winner_valid, winner_idx, winner_time);
      else passes++;
      $display("closing winner: pd=%b v=%b i=%0d t=%0d", period_done, winner_valid, winner_idx, winner_time);
   endtask

   task automatic test_tie();
      logic [1:0] exp_second;
`ifdef WTA_RR_TIE_EN
      exp_second = 2'd3;
`else
      exp_second = 2'd1;
`endif
      set_in(1'b1, 3'd0, 4'b1010);
      checks++;
      if (out_spikes !== 4'b0010) $display("FAIL tie1_out: got %b want 0010", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if (period_done !== 1'b0) $display("FAIL pd_one_clock: got %b want 0", period_done);
      else passes++;
      checks++;
      if ({winner_valid, winner_idx, winner_time} !== {1'b1, 2'd1, 3'd0})
         $display("FAIL tie1_regs: got v=%b i=%0d t=%0d want 1 1 0", winner_valid, winner_idx, winner_time);
      else passes++;
      $display("tie period 1: i=%0d", winner_idx);
      for (int c = 1; c < 8; c++) begin
         set_in(1'b1, 3'(c), 4'b0000);
         clk_edge();
      end
      set_in(1'b1, 3'd0, 4'b1010);
      checks++;
      if (out_spikes !== (4'b0001 << exp_second))
         $display("FAIL tie2_out: got %b want %b", out_spikes, 4'b0001 << exp_second);
      else passes++;
      clk_edge();
      checks++;
      if (winner_idx !== exp_second) $display("FAIL tie2_idx: got %0d want %0d", winner_idx, exp_second);
      else passes++;
      $display("tie period 2: i=%0d", winner_idx);
   endtask

   task automatic test_missed_close();
      set_in(1'b1, 3'd0, 4'b0100);
      checks++;
      if (out_spikes !== 4'b0100) $display("FAIL missed_out: got %b want 0100", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if ({winner_valid, winner_idx, winner_time} !== {1'b1, 2'd2, 3'd0})
         $display("FAIL missed_regs: got v=%b i=%0d t=%0d want 1 2 0", winner_valid, winner_idx, winner_time);
      else passes++;
      $display("missed close: i=%0d t=%0d", winner_idx, winner_time);
   endtask

   task automatic test_reset_mid();
      set_in(1'b1, 3'd2, 4'b0001);
      checks++;
      if (out_spikes !== 4'b0000) $display("FAIL mid_locked_out: got %b want 0000", out_spikes);
      else passes++;
      clk_edge();
      rst = 1'b1;
      set_in(1'b1, 3'd3, 4'b1111);
      checks++;
      if (out_spikes !== 4'b0000) $display("FAIL mid_rst_out: got %b want 0000", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if ({winner_valid, winner_idx, winner_time, period_done} !== 7'b0)
         $display("FAIL mid_rst_regs: got v=%b i=%0d t=%0d pd=%b want all 0",
                  winner_valid, winner_idx, winner_time, period_done);
      else passes++;
      rst = 1'b0;
      set_in(1'b0, 3'd3, 4'b1111);
      checks++;
      if (out_spikes !== 4'b0000) $display("FAIL gate_armed_out: got %b want 0000", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if (winner_valid !== 1'b0) $display("FAIL gate_armed_valid: got %b want 0", winner_valid);
      else passes++;
      set_in(1'b1, 3'd3, 4'b0001);
      checks++;
      if (out_spikes !== 4'b0001) $display("FAIL post_rst_out: got %b want 0001", out_spikes);
      else passes++;
      clk_edge();
      checks++;
      if ({winner_valid, winner_idx, winner_time} !== {1'b1, 2'd0, 3'd3})
         $display("FAIL post_rst_regs: got v=%b i=%0d t=%0d want 1 0 3", winner_valid, winner_idx, winner_time);
      else passes++;
      $display("reset mid-period: v=%b i=%0d t=%0d", winner_valid, winner_idx, winner_time);
   endtask

   initial begin
      rst        = 1'b1;
      en_counter = 1'b0;
      cycle      = '0;
      in_spikes  = '0;
      test_reset();
      test_single_spike();
      test_suppression();
      test_gating_locked();
      test_period_close();
      test_closing_winner();
      test_tie();
      test_missed_close();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
